// File: rtl/mnist_result_collector.sv
// rtl/mnist_result_collector.sv - collects a logit stream from the network core, tracks the signed argmax, and holds the logits for readback
module mnist_result_collector #(
    parameter int NUM_CLASSES    = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_result_valid,
    input  logic [IDX_WIDTH-1:0]  i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_busy,
    output logic                  o_pred_valid,
    output logic [IDX_WIDTH-1:0]  o_pred_class,
    output logic [DATA_WIDTH-1:0] o_pred_max,
    output logic                  o_timeout,
    output logic                  o_extra_err
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [31:0]          TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t                r_state;
    state_t                w_next;
    logic [IDX_WIDTH-1:0]  r_count;
    logic [31:0]           r_timer;
    logic [DATA_WIDTH-1:0] r_max;
    logic [IDX_WIDTH-1:0]  r_arg;
    logic                  r_pred_valid;
    logic                  r_timeout;
    logic                  r_extra_err;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_logit [NUM_CLASSES];
    logic                  w_collect;
    logic                  w_last;
    logic                  w_expire;

    // start pre-empts everything, including a result sampled in the same cycle
    assign w_collect = (r_state == S_COLLECT) && !i_start;
    assign w_last    = w_collect && i_result_valid && (r_count == LAST_IDX);
    assign w_expire  = TMO_EN && w_collect && !w_last && (r_timer == TMO_LAST);

    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = S_COLLECT;
        end else if (w_last) begin
            w_next = S_DONE;
        end else if (w_expire) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_timer      <= '0;
            r_max        <= '0;
            r_arg        <= '0;
            r_pred_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_extra_err  <= 1'b0;
            r_rd_data    <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_logit[i] <= '0;
            end
        end else begin
            r_state      <= w_next;
            r_pred_valid <= w_last;
            r_rd_data    <= (i_rd_idx <= LAST_IDX) ? r_logit[i_rd_idx] : '0;

            if (i_start) begin
                r_count     <= '0;
                r_timer     <= '0;
                r_timeout   <= 1'b0;
                r_extra_err <= 1'b0;
            end else if (w_collect) begin
                r_timer <= r_timer + 32'd1;
                if (w_expire) begin
                    r_timeout <= 1'b1;
                end
                if (i_result_valid) begin
                    r_logit[r_count] <= i_result;
                    if (r_count == '0) begin
                        r_max <= i_result;
                        r_arg <= '0;
                    end else if ($signed(i_result) > $signed(r_max)) begin
                        r_max <= i_result;
                        r_arg <= r_count;
                    end
                    // count stops at the last index so it can never wrap
                    if (!w_last) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end else if (i_result_valid) begin
                r_extra_err <= 1'b1;
            end
        end
    end

    assign o_busy       = (r_state == S_COLLECT);
    assign o_pred_valid = r_pred_valid;
    assign o_pred_class = r_arg;
    assign o_pred_max   = r_max;
    assign o_timeout    = r_timeout;
    assign o_extra_err  = r_extra_err;
    assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_mnist_result_collector.sv
// tb/tb_mnist_result_collector.sv - directed bench for mnist_result_collector
module tb_mnist_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] result;
    logic        result_valid;
    logic [3:0]  rd_idx;
    logic [31:0] rd_data;
    logic        busy;
    logic        pred_valid;
    logic [3:0]  pred_class;
    logic [31:0] pred_max;
    logic        timeout;
    logic        extra_err;

    int n_checks = 0;
    int n_pass   = 0;
    int pv_count = 0;
    int img [10];

    always #5 clk = ~clk;

    always @(negedge clk) if (pred_valid) pv_count++;

    mnist_result_collector #(
        .NUM_CLASSES(10), .DATA_WIDTH(32), .IDX_WIDTH(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_result(result),
        .i_result_valid(result_valid), .i_rd_idx(rd_idx), .o_rd_data(rd_data),
        .o_busy(busy), .o_pred_valid(pred_valid), .o_pred_class(pred_class),
        .o_pred_max(pred_max), .o_timeout(timeout), .o_extra_err(extra_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send(input int v);
        result       = v;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic collect(input int gap, input int exp_cls, input int exp_max);
        int pv0;
        pv0 = pv_count;
        for (int i = 0; i < 10; i++) begin
            send(img[i]);
            if (i < 9) begin
                for (int g = 0; g < gap; g++) begin
                    if (busy !== 1'b1) check("busy_in_gap", 32'(busy), 32'd1);
                    tick();
                end
            end
        end
        check("pred_valid_set", 32'(pred_valid), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("pred_class", 32'(pred_class), 32'(exp_cls));
        check("pred_max", pred_max, 32'(exp_max));
        tick();
        check("pred_valid_pulse", 32'(pred_valid), 32'd0);
        check("pred_valid_count", 32'(pv_count - pv0), 32'd1);
    endtask

    task automatic readback(input int idx, input int exp);
        rd_idx = 4'(idx);
        tick();
        check($sformatf("rd_data[%0d]", idx), rd_data, 32'(exp));
    endtask

    initial begin
        int n;
        int pv0;
        rst = 1'b1; start = 1'b0; result = '0; result_valid = 1'b0; rd_idx = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_pred_class", 32'(pred_class), 32'd0);
        check("rst_pred_max", pred_max, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_flags", {30'd0, timeout, extra_err}, 32'd0);

        // T1: tie keeps the lowest index
        img = '{5, -3, 9, 9, 0, 1, 2, 3, 4, -8};
        pulse_start();
        collect(0, 2, 9);

        // T2: all negative, gapped stream
        img = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
        pulse_start();
        collect(3, 9, -91);

        // T3: extremes of the signed range
        img[0] = 32'h7FFFFFFF;
        for (int i = 1; i < 10; i++) img[i] = int'(32'h80000000);
        pulse_start();
        collect(0, 0, 32'h7FFFFFFF);
        send(55);
        check("extra_err_in_done", 32'(extra_err), 32'd1);

        // T4: timeout after 6 of 10 logits
        img = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
        pulse_start();
        check("start_clears_extra", 32'(extra_err), 32'd0);
        pv0 = pv_count;
        n = 1;
        for (int i = 0; i < 6; i++) begin
            send(img[i]);
            if (timeout) break;
            n++;
        end
        while (!timeout && n < 200) begin
            tick();
            if (!timeout) n++;
        end
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_cycles", 32'(n), 32'd50);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_no_pred", 32'(pv_count - pv0), 32'd0);

        // T5: unsolicited result in IDLE, then start+valid in the same cycle
        readback(0, 11);
        send(77);
        check("extra_err_idle", 32'(extra_err), 32'd1);
        readback(0, 11);
        readback(6, 32'h80000000);
        start = 1'b1; result = 1234; result_valid = 1'b1;
        tick();
        start = 1'b0; result_valid = 1'b0;
        check("same_cycle_extra", 32'(extra_err), 32'd0);
        check("restart_timeout_clr", 32'(timeout), 32'd0);
        img = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        collect(0, 5, 9);
        readback(0, 3);

        // T6: reset mid-collect, then a clean run and full readback
        pulse_start();
        for (int i = 0; i < 5; i++) send(100 + i);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pred", {pred_class, 27'd0, pred_valid}, 32'd0);
        check("mid_rst_max", pred_max, 32'd0);
        check("mid_rst_flags", {30'd0, timeout, extra_err}, 32'd0);
        rst = 1'b0;
        readback(0, 0);
        img = '{5, -3, 9, 9, 0, 1, 2, 3, 4, -8};
        pulse_start();
        collect(1, 2, 9);
        for (int i = 0; i < 10; i++) readback(i, img[i]);
        readback(12, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
